// File: rtl/tdm_mux.sv
// Four-channel TDM transmitter: snapshots data0..data3 and serialises them onto line/adr, with DWELL cycles per slot.
// Optional macro TDM_CONT_EN selects continuous scanning. When it is undefined, each frame is gated by start.
module tdm_mux #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       data0,
  input  logic       data1,
  input  logic       data2,
  input  logic       data3,
  output logic       line,
  output logic [1:0] adr,
  output logic       valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [7:0] DLAST = 8'(DWELL - 1);

  state_t      state_q, state_d;
  logic [3:0]  snap_q, snap_d;
  logic [7:0]  dcnt_q, dcnt_d;
  logic [1:0]  adr_q, adr_d;
  logic        line_q, line_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [3:0]  data_in;
  logic [1:0]  adr_nxt;
  logic        go;

  assign data_in = {data3, data2, data1, data0};
  assign adr_nxt = adr_q + 2'd1;

`ifdef TDM_CONT_EN
  // Continuous scan: leave IDLE on the first edge out of reset.
  assign go = 1'b1;
`else
  assign go = start;
`endif

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    dcnt_d  = dcnt_q;
    adr_d   = adr_q;
    line_d  = line_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        line_d = 1'b0;
        if (go) begin
          state_d = SEND;
          snap_d  = data_in;
          dcnt_d  = 8'd0;
          adr_d   = 2'd0;
          line_d  = data_in[0];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      SEND: begin
        if (dcnt_q == DLAST) begin
          dcnt_d = 8'd0;
          if (adr_q == 2'd3) begin
            done_d = 1'b1;
            adr_d  = 2'd0;
`ifdef TDM_CONT_EN
            snap_d = data_in;
            line_d = data_in[0];
`else
            state_d = IDLE;
            line_d  = 1'b0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
`endif
          end else begin
            adr_d  = adr_nxt;
            line_d = snap_q[adr_nxt];
          end
        end else begin
          dcnt_d = dcnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      snap_q  <= 4'd0;
      dcnt_q  <= 8'd0;
      adr_q   <= 2'd0;
      line_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      dcnt_q  <= dcnt_d;
      adr_q   <= adr_d;
      line_q  <= line_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign line  = line_q;
  assign adr   = adr_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_tdm_mux.sv
// Directed bench for tdm_mux (default build): DWELL=4 and DWELL=1 instances driven from tables and hand sequences.
module tb_tdm_mux;

  logic       clk = 1'b0;
  logic       rst;
  logic       start4, start1;
  logic [3:0] data;
  logic       line4, valid4, busy4, done4;
  logic [1:0] adr4;
  logic       line1, valid1, busy1, done1;
  logic [1:0] adr1;

  tdm_mux #(.DWELL(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4),
    .data0(data[0]), .data1(data[1]), .data2(data[2]), .data3(data[3]),
    .line(line4), .adr(adr4), .valid(valid4), .busy(busy4), .done(done4)
  );

  tdm_mux #(.DWELL(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .data0(data[0]), .data1(data[1]), .data2(data[2]), .data3(data[3]),
    .line(line1), .adr(adr1), .valid(valid1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic [3:0] data;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  // Packed observation: {line, adr, valid, busy, done}
  function automatic logic [5:0] ex(input logic l, input logic [1:0] a,
                                    input logic v, input logic b, input logic d);
    return {l, a, v, b, d};
  endfunction

  function automatic logic [5:0] obs4();
    return {line4, adr4, valid4, busy4, done4};
  endfunction

  function automatic logic [5:0] obs1();
    return {line1, adr1, valid1, busy1, done1};
  endfunction

  task automatic chk(input string nm, input int idx, input logic [5:0] act, input logic [5:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s[%0d] actual={line,adr,v,b,d}=%b required=%b", nm, idx, act, req);
    end
  endtask

  task automatic step(input logic s, input logic [3:0] d);
    @(negedge clk);
    start4 = s;
    data   = d;
    @(posedge clk);
    #1;
  endtask

  // One DWELL=4 frame: start on the first vector, 16 slot cycles, done cycle, one idle cycle.
  task automatic add_frame(input logic [3:0] d);
    for (int c = 0; c < 16; c++) begin
      vec_t v;
      v.start = (c == 0);
      v.data  = d;
      v.exp   = ex(d[c / 4], 2'(c / 4), 1'b1, 1'b1, 1'b0);
      tbl.push_back(v);
    end
    begin
      vec_t v;
      v.start = 1'b0; v.data = d; v.exp = ex(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
      tbl.push_back(v);
      v.exp = 6'd0;
      tbl.push_back(v);
    end
  endtask

  task automatic run_table(input string nm);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].start, tbl[i].data);
      chk(nm, i, obs4(), tbl[i].exp);
    end
    tbl.delete();
  endtask

  initial begin
    rst = 1'b1; start4 = 1'b0; start1 = 1'b0; data = 4'd0;

    // Reset, then idle with start low.
    #1;
    chk("reset_async", 0, obs4(), 6'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_held", 0, obs4(), 6'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'b1111);
      chk("idle", i, obs4(), 6'd0);
      chk("idle_d1", i, obs1(), 6'd0);
    end

    // Single frame, data 1011 -> line 1,1,0,1.
    add_frame(4'b1011);
    run_table("frame_1011");

    // Snapshot isolation: data flips after capture, and a start pulse during SEND is ignored.
    add_frame(4'b0001);
    for (int i = 1; i < tbl.size(); i++) tbl[i].data = 4'b1110;
    tbl[5].start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vec_t v;
      v.start = 1'b0; v.data = 4'b1110; v.exp = 6'd0;
      tbl.push_back(v);
    end
    run_table("snap_iso");

    // Reset during slot 2: outputs clear asynchronously and no done pulse follows.
    step(1'b1, 4'b1011);
    for (int i = 0; i < 8; i++) step(1'b0, 4'b1011);
    chk("slot2_entry", 0, obs4(), ex(1'b0, 2'd2, 1'b1, 1'b1, 1'b0));
    #2;
    rst = 1'b1;
    #1;
    chk("mid_reset_async", 0, obs4(), 6'd0);
    @(posedge clk);
    #1;
    chk("mid_reset_held", 0, obs4(), 6'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 4'b1011);
      chk("post_reset_idle", i, obs4(), 6'd0);
    end
    add_frame(4'b0110);
    run_table("frame_0110");

    // DWELL=1 with start held: 4-cycle frames separated by one done cycle.
    @(negedge clk);
    data   = 4'b1011;
    start1 = 1'b1;
    for (int i = 0; i < 15; i++) begin
      int   k;
      logic [5:0] req;
      @(posedge clk);
      #1;
      k = i % 5;
      if (k == 4) req = ex(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
      else        req = ex(data[k], 2'(k), 1'b1, 1'b1, 1'b0);
      chk("dwell1_b2b", i, obs1(), req);
    end
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
    end
    chk("dwell1_stop", 0, obs1(), 6'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
